// File: rtl/crb_fifo_xfer.sv
// CRB-side transfer engine: copies command bytes FIFO->CRB, responses CRB->FIFO.
// Optional header-size check is compiled in with CRB_XFER_HDRCHK_EN.
module crb_fifo_xfer #(
  parameter int ADDR_W   = 12,
  parameter int BUF_SIZE = 4096,
  parameter int RSP_LEAD = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              f_abort,
  input  logic              c_cmdSend,
  input  logic [31:0]       c_cmdSize,
  output logic [ADDR_W-1:0] c_cmdInAddr,
  input  logic [7:0]        cmdByteOut,
  output logic              c_cmdDone,
  output logic              e_cmdReady,
  input  logic              e_execDone,
  input  logic [31:0]       e_rspSize,
  output logic [31:0]       c_rspSize,
  output logic              c_rspSend,
  output logic [ADDR_W-1:0] c_rspInAddr,
  output logic [7:0]        rspByteIn,
  output logic              c_rspDone,
  output logic [ADDR_W-1:0] m_addr,
  output logic [7:0]        m_wrByte,
  output logic              m_wren_n,
  input  logic [7:0]        m_rdByte,
  output logic              x_busy,
  output logic              x_trunc,
  output logic              x_hdrErr
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] BUF_LEN = CW'(BUF_SIZE);
  localparam logic [7:0] LEAD_LAST = 8'(RSP_LEAD - 2);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD_RD,
    S_CMD_DRAIN,
    S_CMD_DONE,
    S_EXEC_WAIT,
    S_RSP_LEAD,
    S_RSP_RD,
    S_RSP_DRAIN,
    S_RSP_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     len_q, len_d;
  logic [CW-1:0]     idx_q, idx_d;
  logic [7:0]        lead_q, lead_d;
  logic [ADDR_W-1:0] c_cmdInAddr_q, c_cmdInAddr_d;
  logic              c_cmdDone_q, c_cmdDone_d;
  logic [31:0]       c_rspSize_q, c_rspSize_d;
  logic              c_rspSend_q, c_rspSend_d;
  logic [ADDR_W-1:0] c_rspInAddr_q, c_rspInAddr_d;
  logic              c_rspDone_q, c_rspDone_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic              m_wren_n_q, m_wren_n_d;
  logic              x_trunc_q, x_trunc_d;

  logic [CW-1:0] idx_inc;
  logic          idx_last;
  logic [CW-1:0] cmd_len;
  logic [CW-1:0] rsp_len;

  function automatic logic [CW-1:0] clamp_len(
    input logic [31:0] sz
  );
    logic [CW-1:0] r;
    if (sz > 32'(BUF_SIZE)) r = BUF_LEN;
    else r = sz[CW-1:0];
    return r;
  endfunction

  assign idx_inc  = idx_q + CW'(1);
  assign idx_last = (idx_q == len_q - CW'(1));
  assign cmd_len  = clamp_len(c_cmdSize);
  assign rsp_len  = clamp_len(e_rspSize);

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    idx_d         = idx_q;
    lead_d        = lead_q;
    c_cmdInAddr_d = c_cmdInAddr_q;
    c_rspSize_d   = c_rspSize_q;
    c_rspSend_d   = 1'b1;
    c_rspInAddr_d = c_rspInAddr_q;
    m_addr_d      = m_addr_q;
    m_wren_n_d    = 1'b1;
    x_trunc_d     = x_trunc_q;
    if (f_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (c_cmdSend) begin
            len_d         = cmd_len;
            idx_d         = '0;
            c_cmdInAddr_d = '0;
            if (c_cmdSize > 32'(BUF_SIZE)) x_trunc_d = 1'b1;
            if (cmd_len == '0) state_d = S_CMD_DONE;
            else state_d = S_CMD_RD;
          end
        end
        S_CMD_RD: begin
          // write lags the FIFO read address by one cycle
          m_wren_n_d = 1'b0;
          m_addr_d   = c_cmdInAddr_q;
          if (idx_last) begin
            state_d = S_CMD_DRAIN;
          end else begin
            idx_d         = idx_inc;
            c_cmdInAddr_d = idx_inc[ADDR_W-1:0];
          end
        end
        S_CMD_DRAIN: state_d = S_CMD_DONE;
        S_CMD_DONE:  state_d = S_EXEC_WAIT;
        S_EXEC_WAIT: begin
          if (e_execDone) begin
            c_rspSize_d = e_rspSize;
            len_d       = rsp_len;
            lead_d      = '0;
            state_d     = S_RSP_LEAD;
            if (e_rspSize > 32'(BUF_SIZE)) x_trunc_d = 1'b1;
          end
        end
        S_RSP_LEAD: begin
          if (lead_q == LEAD_LAST) begin
            m_addr_d = '0;
            idx_d    = '0;
            if (len_q == '0) state_d = S_RSP_DRAIN;
            else state_d = S_RSP_RD;
          end else begin
            lead_d = lead_q + 8'd1;
          end
        end
        S_RSP_RD: begin
          c_rspSend_d   = 1'b0;
          c_rspInAddr_d = m_addr_q;
          if (idx_last) begin
            state_d = S_RSP_DRAIN;
          end else begin
            idx_d    = idx_inc;
            m_addr_d = idx_inc[ADDR_W-1:0];
          end
        end
        S_RSP_DRAIN: state_d = S_RSP_DONE;
        S_RSP_DONE:  state_d = S_IDLE;
        default:     state_d = S_IDLE;
      endcase
    end
    c_cmdDone_d = (state_d == S_CMD_DONE);
    c_rspDone_d = (state_d == S_RSP_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      idx_q         <= '0;
      lead_q        <= '0;
      c_cmdInAddr_q <= '0;
      c_cmdDone_q   <= 1'b0;
      c_rspSize_q   <= '0;
      c_rspSend_q   <= 1'b1;
      c_rspInAddr_q <= '0;
      c_rspDone_q   <= 1'b0;
      m_addr_q      <= '0;
      m_wren_n_q    <= 1'b1;
      x_trunc_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      idx_q         <= idx_d;
      lead_q        <= lead_d;
      c_cmdInAddr_q <= c_cmdInAddr_d;
      c_cmdDone_q   <= c_cmdDone_d;
      c_rspSize_q   <= c_rspSize_d;
      c_rspSend_q   <= c_rspSend_d;
      c_rspInAddr_q <= c_rspInAddr_d;
      c_rspDone_q   <= c_rspDone_d;
      m_addr_q      <= m_addr_d;
      m_wren_n_q    <= m_wren_n_d;
      x_trunc_q     <= x_trunc_d;
    end
  end

  // read data arrives with one-cycle latency, so it passes straight through
  assign m_wrByte  = m_wren_n_q ? 8'h00 : cmdByteOut;
  assign rspByteIn = c_rspSend_q ? 8'h00 : m_rdByte;

  assign c_cmdInAddr = c_cmdInAddr_q;
  assign c_cmdDone   = c_cmdDone_q;
  assign e_cmdReady  = c_cmdDone_q;
  assign c_rspSize   = c_rspSize_q;
  assign c_rspSend   = c_rspSend_q;
  assign c_rspInAddr = c_rspInAddr_q;
  assign c_rspDone   = c_rspDone_q;
  assign m_addr      = m_addr_q;
  assign m_wren_n    = m_wren_n_q;
  assign x_trunc     = x_trunc_q;
  assign x_busy      = !(state_q == S_IDLE ||
                         state_q == S_EXEC_WAIT);

`ifdef CRB_XFER_HDRCHK_EN
  logic [31:0] hdr_q, hdr_d;
  logic [31:0] size_q, size_d;
  logic        x_hdrErr_q, x_hdrErr_d;
  logic        cmd_hdr_byte;
  logic        rsp_hdr_byte;

  assign cmd_hdr_byte = !m_wren_n_q &&
                        m_addr_q >= ADDR_W'(2) &&
                        m_addr_q <= ADDR_W'(5);
  assign rsp_hdr_byte = !c_rspSend_q &&
                        c_rspInAddr_q >= ADDR_W'(2) &&
                        c_rspInAddr_q <= ADDR_W'(5);

  // bytes 2..5 shift in big-endian; hdr_d covers a header ending in drain
  always_comb begin
    hdr_d      = hdr_q;
    size_d     = size_q;
    x_hdrErr_d = x_hdrErr_q;
    if (cmd_hdr_byte) hdr_d = {hdr_q[23:0], cmdByteOut};
    else if (rsp_hdr_byte) hdr_d = {hdr_q[23:0], m_rdByte};
    if (state_q == S_IDLE && c_cmdSend) size_d = c_cmdSize;
    if (!f_abort && len_q >= CW'(6)) begin
      if (state_q == S_CMD_DRAIN && hdr_d != size_q)
        x_hdrErr_d = 1'b1;
      if (state_q == S_RSP_DRAIN && hdr_d != c_rspSize_q)
        x_hdrErr_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hdr_q      <= '0;
      size_q     <= '0;
      x_hdrErr_q <= 1'b0;
    end else begin
      hdr_q      <= hdr_d;
      size_q     <= size_d;
      x_hdrErr_q <= x_hdrErr_d;
    end
  end

  assign x_hdrErr = x_hdrErr_q;
`else
  assign x_hdrErr = 1'b0;
`endif

endmodule

// File: tb/tb_crb_fifo_xfer.sv
// Bench for crb_fifo_xfer: FIFO/CRB memory models plus a length/timing model.
module tb_crb_fifo_xfer;
  localparam int AW   = 12;
  localparam int BUF  = 4096;
  localparam int LEAD = 2;
`ifdef CRB_XFER_HDRCHK_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          f_abort = 1'b0;
  logic          c_cmdSend = 1'b0;
  logic [31:0]   c_cmdSize = '0;
  logic [AW-1:0] c_cmdInAddr;
  logic [7:0]    cmdByteOut;
  logic          c_cmdDone;
  logic          e_cmdReady;
  logic          e_execDone = 1'b0;
  logic [31:0]   e_rspSize = '0;
  logic [31:0]   c_rspSize;
  logic          c_rspSend;
  logic [AW-1:0] c_rspInAddr;
  logic [7:0]    rspByteIn;
  logic          c_rspDone;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_wrByte;
  logic          m_wren_n;
  logic [7:0]    m_rdByte;
  logic          x_busy;
  logic          x_trunc;
  logic          x_hdrErr;

  crb_fifo_xfer #(.ADDR_W(AW), .BUF_SIZE(BUF), .RSP_LEAD(LEAD)) dut (
    .clock(clock), .reset(reset), .f_abort(f_abort),
    .c_cmdSend(c_cmdSend), .c_cmdSize(c_cmdSize),
    .c_cmdInAddr(c_cmdInAddr), .cmdByteOut(cmdByteOut),
    .c_cmdDone(c_cmdDone), .e_cmdReady(e_cmdReady),
    .e_execDone(e_execDone), .e_rspSize(e_rspSize),
    .c_rspSize(c_rspSize), .c_rspSend(c_rspSend),
    .c_rspInAddr(c_rspInAddr), .rspByteIn(rspByteIn),
    .c_rspDone(c_rspDone), .m_addr(m_addr),
    .m_wrByte(m_wrByte), .m_wren_n(m_wren_n),
    .m_rdByte(m_rdByte), .x_busy(x_busy),
    .x_trunc(x_trunc), .x_hdrErr(x_hdrErr)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] fifo_mem [BUF];
  logic [7:0] fifo_out [BUF];
  logic [7:0] crb [BUF];
  logic [7:0] fifo_rd = '0;
  logic [7:0] crb_rd = '0;
  logic [7:0] pat1 [10] = '{8'h80, 8'h01, 8'h00, 8'h00, 8'h00,
                            8'h0A, 8'h00, 8'h00, 8'h01, 8'h44};

  assign cmdByteOut = fifo_rd;
  assign m_rdByte   = crb_rd;

  always @(posedge clock) begin
    fifo_rd <= fifo_mem[c_cmdInAddr];
    crb_rd  <= crb[m_addr];
    if (!m_wren_n) crb[m_addr] = m_wrByte;
    if (!c_rspSend) fifo_out[c_rspInAddr] = rspByteIn;
  end

  int cmd_done_cnt = 0;
  int cmd_done_cyc = 0;
  int rdy_cyc = 0;
  int wren_cnt = 0;
  int rsp_done_cnt = 0;
  int rsp_done_cyc = 0;
  logic hdr_at_done = 1'b0;
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];

  always @(negedge clock) begin
    if (!reset) begin
      if (c_cmdDone) begin
        cmd_done_cnt++;
        cmd_done_cyc = cyc;
        hdr_at_done = x_hdrErr;
      end
      if (e_cmdReady) rdy_cyc = cyc;
      if (!m_wren_n) wren_cnt++;
      if (!c_rspSend) begin
        wr_addr_q.push_back(int'(c_rspInAddr));
        wr_data_q.push_back(int'(rspByteIn));
        wr_cyc_q.push_back(cyc);
      end
      if (c_rspDone) begin
        rsp_done_cnt++;
        rsp_done_cyc = cyc;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int tb_len(input int unsigned size);
    if (size > BUF) return BUF;
    return int'(size);
  endfunction

  // mode 0: random body, correct header; 1: fixed pattern; 2: bad header
  task automatic do_cmd(input int size, input int mode);
    int len, s, n0, bad, exp_done;
    logic [31:0] sz;
    len = tb_len(size);
    sz = size;
    if (mode == 0) begin
      for (int i = 0; i < len; i++) fifo_mem[i] = 8'($urandom);
      fifo_mem[2] = sz[31:24];
      fifo_mem[3] = sz[23:16];
      fifo_mem[4] = sz[15:8];
      fifo_mem[5] = sz[7:0];
    end else begin
      for (int i = 0; i < 10; i++) fifo_mem[i] = pat1[i];
      if (mode == 2) begin
        fifo_mem[2] = 8'h00;
        fifo_mem[3] = 8'h00;
        fifo_mem[4] = 8'h00;
        fifo_mem[5] = 8'h0C;
      end
    end
    for (int i = 0; i < len; i++) crb[i] = ~fifo_mem[i];
    wren_cnt = 0;
    n0 = cmd_done_cnt;
    c_cmdSize = sz;
    c_cmdSend = 1'b1;
    s = cyc;
    step();
    c_cmdSend = 1'b0;
    chk("cmd_busy", 32'(x_busy), 32'd1);
    for (int i = 0; i < len + 20 && cmd_done_cnt == n0; i++) step();
    exp_done = (len == 0) ? s + 1 : s + len + 2;
    chk("cmd_done_seen", cmd_done_cnt - n0, 32'd1);
    chk("cmd_done_cyc", cmd_done_cyc, exp_done);
    chk("cmd_ready_cyc", rdy_cyc, exp_done);
    chk("cmd_wr_count", wren_cnt, len);
    bad = 0;
    for (int i = 0; i < len; i++)
      if (crb[i] !== fifo_mem[i]) bad++;
    chk("cmd_crb_data", bad, 32'd0);
    chk("cmd_hdr_err", 32'(hdr_at_done),
        32'(mode == 2 && HDR_EN));
    chk("exec_wait_free", 32'(x_busy), 32'd0);
  endtask

  task automatic do_rsp(input int size, input int inject);
    int len, t, n0, c0, bad;
    logic [31:0] sz;
    len = tb_len(size);
    sz = size;
    for (int i = 0; i < len; i++) crb[i] = 8'($urandom);
    if (len >= 6) begin
      crb[2] = sz[31:24];
      crb[3] = sz[23:16];
      crb[4] = sz[15:8];
      crb[5] = sz[7:0];
    end
    for (int i = 0; i < len; i++) fifo_out[i] = ~crb[i];
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    n0 = rsp_done_cnt;
    c0 = cmd_done_cnt;
    e_rspSize = sz;
    e_execDone = 1'b1;
    t = cyc;
    step();
    e_execDone = 1'b0;
    chk("rsp_size_reg", c_rspSize, sz);
    if (inject > 0) begin
      while (cyc < t + inject) step();
      c_cmdSize = 32'd3;
      c_cmdSend = 1'b1;
      step();
      c_cmdSend = 1'b0;
    end
    for (int i = 0; i < len + 20 && rsp_done_cnt == n0; i++) step();
    chk("rsp_done_seen", rsp_done_cnt - n0, 32'd1);
    chk("rsp_done_cyc", rsp_done_cyc, t + LEAD + len + 1);
    chk("rsp_wr_count", wr_addr_q.size(), len);
    bad = 0;
    for (int i = 0; i < wr_addr_q.size(); i++) begin
      if (wr_addr_q[i] != i) bad++;
      if (wr_data_q[i] != int'(crb[i])) bad++;
      if (wr_cyc_q[i] != t + LEAD + 1 + i) bad++;
    end
    chk("rsp_wr_seq", bad, 32'd0);
    bad = 0;
    for (int i = 0; i < len; i++)
      if (fifo_out[i] !== crb[i]) bad++;
    chk("rsp_fifo_data", bad, 32'd0);
    step();
    chk("rsp_idle", 32'(x_busy), 32'd0);
    if (inject > 0)
      chk("rsp_cmd_ignored", cmd_done_cnt, c0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, n0, last_rsp;
    repeat (3) step();
    chk("rst_cmdInAddr", 32'(c_cmdInAddr), 32'd0);
    chk("rst_cmdDone", 32'(c_cmdDone), 32'd0);
    chk("rst_cmdReady", 32'(e_cmdReady), 32'd0);
    chk("rst_rspSize", c_rspSize, 32'd0);
    chk("rst_rspSend", 32'(c_rspSend), 32'd1);
    chk("rst_rspInAddr", 32'(c_rspInAddr), 32'd0);
    chk("rst_rspByteIn", 32'(rspByteIn), 32'd0);
    chk("rst_rspDone", 32'(c_rspDone), 32'd0);
    chk("rst_m_addr", 32'(m_addr), 32'd0);
    chk("rst_m_wrByte", 32'(m_wrByte), 32'd0);
    chk("rst_m_wren_n", 32'(m_wren_n), 32'd1);
    chk("rst_busy", 32'(x_busy), 32'd0);
    chk("rst_trunc", 32'(x_trunc), 32'd0);
    chk("rst_hdrErr", 32'(x_hdrErr), 32'd0);
    reset = 1'b0;
    step();

    do_cmd(10, 1);
    do_rsp(10, 0);

    repeat (12) begin
      do_cmd(int'($urandom_range(0, 40)), 0);
      last_rsp = int'($urandom_range(0, 40));
      do_rsp(last_rsp, 0);
    end

    // response request while idle must be ignored
    n0 = rsp_done_cnt;
    wr_addr_q.delete();
    e_rspSize = 32'd77;
    e_execDone = 1'b1;
    step();
    e_execDone = 1'b0;
    repeat (6) step();
    chk("idle_exec_busy", 32'(x_busy), 32'd0);
    chk("idle_exec_size", c_rspSize, last_rsp);
    chk("idle_exec_wr", wr_addr_q.size(), 32'd0);
    chk("idle_exec_done", rsp_done_cnt, n0);
    do_cmd(4, 0);
    do_rsp(20, 3);

    // abort part-way through a command
    for (int i = 0; i < 10; i++) fifo_mem[i] = 8'($urandom);
    wren_cnt = 0;
    n0 = cmd_done_cnt;
    c_cmdSize = 32'd10;
    c_cmdSend = 1'b1;
    s = cyc;
    step();
    c_cmdSend = 1'b0;
    while (cyc < s + 4) step();
    f_abort = 1'b1;
    step();
    f_abort = 1'b0;
    chk("abort_cyc", cyc, s + 5);
    chk("abort_busy", 32'(x_busy), 32'd0);
    chk("abort_wren", 32'(m_wren_n), 32'd1);
    chk("abort_wr_count", wren_cnt, 32'd3);
    repeat (15) step();
    chk("abort_no_done", cmd_done_cnt, n0);
    chk("abort_wren_idle", 32'(m_wren_n), 32'd1);
    do_cmd(12, 0);
    do_rsp(9, 0);

    chk("trunc_clear", 32'(x_trunc), 32'd0);
    chk("hdr_clear", 32'(x_hdrErr), 32'd0);
    do_cmd(0, 0);
    do_rsp(0, 0);
    do_cmd(5000, 0);
    chk("trunc_set", 32'(x_trunc), 32'd1);
    do_rsp(6, 0);

    do_cmd(10, 2);
    do_rsp(10, 0);
    chk("hdr_final", 32'(x_hdrErr), 32'(HDR_EN));

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
